dual_rail_value_capture: RTL and testbench
==========================================

Name: dual_rail_value_capture

Overview:
- Downstream consumer of the dual-rail transition-protocol (TP) link produced by the value-inject stage.
- Synchronises both rails of every bit into the `clk` domain and detects token completion.
- Decodes each completed token into a binary word, presents it on a valid/ready interface, and returns a 2-phase acknowledge upstream.
- Exerts backpressure on the link by withholding the acknowledge toggle.

Parameters:
- ENC, "TP", link encoding; only "TP" (2-phase, one rail toggles per bit per token) is supported; any other value is an elaboration error.
- WIDTH, 1, number of dual-rail bits per token.
- SYNC_STAGES, 2, flop stages per rail on the input synchroniser; minimum 2.

Ports:
- clk  input  1  single block clock.
- rst  input  1  asynchronous, active-low reset.
- in  input  [WIDTH-1:0][1:0]  dual-rail TP link; [1] is the one-rail, [0] is the zero-rail; asynchronous to clk.
- ack  output  1  2-phase acknowledge to upstream; toggles once per consumed token.
- out_data  output  WIDTH  decoded token value.
- out_valid  output  1  out_data holds an undelivered token.
- out_ready  input  1  consumer accepts out_data when high together with out_valid.
- err  output  1  sticky protocol error: both rails of some bit toggled within one token.

Behaviour:
- Reset (rst low, async assert, sync deassert):
  - Synchroniser flops, ref[WIDTH-1:0][1:0], ack, out_data, out_valid and err all clear to 0.
  - FSM goes to COLLECT.
- Synchroniser: each rail passes through SYNC_STAGES flops; s[b][r] is the last stage.
- Per-bit decode, with diff = s ^ ref:
  - done[b] = diff[b][1] ^ diff[b][0].
  - bad[b] = diff[b][1] & diff[b][0].
  - val[b] = diff[b][1].
- Token complete when &done is true. Token invalid when |bad is true.
- FSM COLLECT:
  - &done and !|bad: out_data <= val, out_valid <= 1, ref <= s, ack <= ~ack, go to HOLD.
  - |bad: err <= 1, ref <= s, ack <= ~ack (token dropped, link kept alive), stay in COLLECT.
  - Otherwise (partial token, bits still skewing): hold, no change.
- FSM HOLD:
  - out_valid is 1 and out_data is stable.
  - On out_valid & out_ready: out_valid <= 0 and go to COLLECT.
  - Same-cycle capture while draining is not performed; the next token is evaluated from the following cycle.
  - Link changes arriving in HOLD are only synchronised; ref does not change, so completion is evaluated on return to COLLECT.
- Latency:
  - Last rail toggle to s: SYNC_STAGES cycles.
  - s to out_valid and ack toggle: 1 cycle.
  - Minimum token-to-token throughput: 2 cycles plus the upstream ack round-trip.
- Ack is registered and glitch-free. Exactly one toggle per consumed or dropped token.
- err stays set until reset; the data path keeps operating after an error.
- Upstream contract: no new rail toggles on any bit until ack has toggled for the previous token. Violation shows up as bad (err) or as a merged token; neither is otherwise detected.
- Reset mid-token:
  - Partially arrived rails are compared against ref = 0 after reset; upstream must also be reset.
  - Any token held in HOLD is discarded.
- WIDTH = 1 is legal; &done reduces to done[0].

Test Plan:
- WIDTH=4, SYNC_STAGES=2; toggle in for value 4'hA (rails [3][1],[2][0],[1][1],[0][0]) -> ack toggles 0→1 and out_valid rises exactly 3 cycles after the toggle; out_data=4'hA; err=0.
- Skewed arrival of 4'h5: bits 0..3 toggled 1 cycle apart -> no capture until bit 3 is synchronised; single ack toggle; out_data=4'h5.
- Backpressure: out_ready=0 after token 4'h3, upstream sends 4'hC after the ack -> out_data stays 4'h3 and ack does not toggle again; raise out_ready -> 4'h3 consumed, next cycle 4'hC captured, ack toggles.
- Both rails of bit 2 toggled in one token -> err=1 sticky, no out_valid, ack toggles; following valid token 4'h1 is delivered with err still 1.
- Back-to-back 16 tokens 0..F with out_ready=1 -> 16 ack toggles, out_data sequence 0..F in order, no duplicates.
- rst low while in HOLD with 4'h7 -> out_valid=0, ack=0, err=0 immediately (async); after release with in=0, no spurious token.

Source files
------------

// File: rtl/dual_rail_value_capture.sv
// Receiver for a dual-rail transition-protocol link: synchronises both rails,
// decodes completed tokens onto a valid/ready port and returns a 2-phase ack.
module dual_rail_value_capture #(
    parameter              ENC         = "TP",
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0][1:0]  in,
    output logic                   ack,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err
);

    generate
        if (ENC != "TP") begin : g_bad_enc
            $error("dual_rail_value_capture: only ENC=\"TP\" is supported");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("dual_rail_value_capture: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0][1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0][1:0]   s;
    logic [WIDTH-1:0][1:0]   ref_q, ref_d;
    logic [WIDTH-1:0][1:0]   diff;
    logic [WIDTH-1:0]        done, bad, val;
    logic                    ack_q, ack_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    tok_done, tok_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A bit is complete when exactly one of its rails moved since the last
    // consumed token; both rails moving is a protocol violation.
    always_comb begin
        diff = s ^ ref_q;
        done = '0;
        bad  = '0;
        val  = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            done[b] = diff[b][1] ^ diff[b][0];
            bad[b]  = diff[b][1] & diff[b][0];
            val[b]  = diff[b][1];
        end
    end

    assign tok_done = &done;
    assign tok_bad  = |bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            ref_q   <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (!tok_bad && tok_done) state_d = HOLD;
            HOLD:    if (valid_q && out_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Bad tokens are still acknowledged so upstream is never left stalled.
    always_comb begin
        ref_d   = ref_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (tok_bad) begin
                    err_d = 1'b1;
                    ref_d = s;
                    ack_d = ~ack_q;
                end else if (tok_done) begin
                    data_d  = val;
                    valid_d = 1'b1;
                    ref_d   = s;
                    ack_d   = ~ack_q;
                end
            end
            HOLD: begin
                if (valid_q && out_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign ack       = ack_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dual_rail_value_capture.sv
// Directed bench for dual_rail_value_capture with WIDTH=4, SYNC_STAGES=2.
module tb_dual_rail_value_capture;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0][1:0] tb_in;
    logic            ack;
    logic [3:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_ack = 1'b0;

    dual_rail_value_capture #(
        .ENC         ("TP"),
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (tb_in),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [3:0] v);
        for (int b = 0; b < 4; b++) tb_in[b][v[b]] = ~tb_in[b][v[b]];
    endtask

    task automatic wait_valid(input string name, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        n_checks++;
        if (k == limit) begin
            n_fail++;
            $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, limit);
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain: out_valid=%b required 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; tb_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack, out_valid, err, out_data} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset: ack=%b valid=%b err=%b data=%h required all 0", ack, out_valid, err, out_data);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        send(4'hA);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== (c == 3)) begin
                n_fail++;
                $display("FAIL single latency cycle %0d: out_valid=%b required %b", c, out_valid, c == 3);
            end
        end
        exp_ack = ~exp_ack;
        n_checks++;
        if (out_data !== 4'hA || ack !== exp_ack || err !== 1'b0) begin
            n_fail++;
            $display("FAIL single: data=%h ack=%b err=%b required A %b 0", out_data, ack, err, exp_ack);
        end
        consume("single");
    endtask

    task automatic test_skew();
        logic [3:0] v;
        v = 4'h5;
        for (int b = 0; b < 4; b++) begin
            tb_in[b][v[b]] = ~tb_in[b][v[b]];
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || ack !== exp_ack) begin
                n_fail++;
                $display("FAIL skew early bit %0d: valid=%b ack=%b required 0 %b", b, out_valid, ack, exp_ack);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skew premature: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        exp_ack = ~exp_ack;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h5 || ack !== exp_ack) begin
            n_fail++;
            $display("FAIL skew capture: valid=%b data=%h ack=%b required 1 5 %b", out_valid, out_data, ack, exp_ack);
        end
        consume("skew");
    endtask

    task automatic test_backpressure();
        send(4'h3);
        wait_valid("bp first", 10);
        exp_ack = ~exp_ack;
        n_checks++;
        if (out_data !== 4'h3 || ack !== exp_ack) begin
            n_fail++;
            $display("FAIL bp first: data=%h ack=%b required 3 %b", out_data, ack, exp_ack);
        end
        send(4'hC);
        repeat (6) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h3 || ack !== exp_ack) begin
            n_fail++;
            $display("FAIL bp hold: valid=%b data=%h ack=%b required 1 3 %b", out_valid, out_data, ack, exp_ack);
        end
        consume("bp first");
        @(negedge clk);
        exp_ack = ~exp_ack;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hC || ack !== exp_ack) begin
            n_fail++;
            $display("FAIL bp second: valid=%b data=%h ack=%b required 1 C %b", out_valid, out_data, ack, exp_ack);
        end
        consume("bp second");
    endtask

    task automatic test_error();
        tb_in[0][0] = ~tb_in[0][0];
        tb_in[1][0] = ~tb_in[1][0];
        tb_in[2]    = ~tb_in[2];
        tb_in[3][0] = ~tb_in[3][0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL error no-valid cycle %0d: out_valid=%b required 0", c, out_valid);
            end
        end
        exp_ack = ~exp_ack;
        n_checks++;
        if (err !== 1'b1 || ack !== exp_ack) begin
            n_fail++;
            $display("FAIL error flag: err=%b ack=%b required 1 %b", err, ack, exp_ack);
        end
        send(4'h1);
        wait_valid("error next", 10);
        exp_ack = ~exp_ack;
        n_checks++;
        if (out_data !== 4'h1 || err !== 1'b1 || ack !== exp_ack) begin
            n_fail++;
            $display("FAIL error next: data=%h err=%b ack=%b required 1 1 %b", out_data, err, ack, exp_ack);
        end
        consume("error next");
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < 16; v++) begin
            send(4'(v));
            wait_valid("b2b", 10);
            exp_ack = ~exp_ack;
            n_checks++;
            if (out_data !== 4'(v) || ack !== exp_ack) begin
                n_fail++;
                $display("FAIL b2b token %0d: data=%h ack=%b required %h %b", v, out_data, ack, 4'(v), exp_ack);
            end
            consume("b2b");
        end
    endtask

    task automatic test_reset_in_hold();
        send(4'h7);
        wait_valid("rst hold", 10);
        n_checks++;
        if (out_data !== 4'h7) begin
            n_fail++;
            $display("FAIL rst hold data: data=%h required 7", out_data);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ack !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: valid=%b ack=%b err=%b required 0 0 0", out_valid, ack, err);
        end
        tb_in = '0;
        exp_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || ack !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL post reset: valid=%b ack=%b err=%b required 0 0 0", out_valid, ack, err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_skew();
        test_backpressure();
        test_error();
        test_back_to_back();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
